wolfram_lut_cell: RTL and testbench
===================================

# wolfram_lut_cell

Runtime-reprogrammable N-input truth-table cell: the parametrised successor to the fixed 3-input rule modules. A truth table is loaded serially into a shadow register, committed atomically, and used to evaluate a stream of input vectors through a valid/ready pipeline with a registered output. It sits between the stimulus sequencer and the output-mapping logic, so one instance replaces any fixed rule.

## Interface
- N_IN, 3: number of logic inputs; 1..6.
- TT_W, 2**N_IN: truth-table width (derived; do not override).
- RESET_TT, 8'hB6: active table after reset; bit i is the output for input vector value i ({in[N_IN-1..0]}, MSB = first input).
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  serial config bit present.
- cfg_bit  in  1  config data; table bit 0 first, bit TT_W-1 last.
- cfg_ready  out  1  config bit accepted when cfg_valid & cfg_ready.
- cfg_done  out  1  one-cycle pulse when a new table commits.
- in_valid  in  1  input vector present.
- in_data  in  N_IN  input vector.
- in_ready  out  1  vector accepted when in_valid & in_ready.
- out_valid  out  1  result present.
- out_data  out  1  truth-table output.
- out_ready  in  1  downstream accepts result.

## Operation
- Reset: active table = RESET_TT, shadow = 0, bit counter = 0, FSM = IDLE; cfg_ready=1, cfg_done=0, in_ready=1, out_valid=0, out_data=0.
- Config FSM: IDLE -> SHIFT on first accepted cfg bit; SHIFT counts accepted bits; on the TT_W-th accepted bit -> COMMIT; COMMIT copies shadow to active table, pulses cfg_done, returns to IDLE. cfg_ready=0 only in COMMIT.
- Counter width $clog2(TT_W)+1; resets to 0 on entering IDLE; no wrap within a load.
- Gaps (cfg_valid low) in SHIFT hold state indefinitely; there is no timeout.
- Evaluation runs concurrently with loading; it always uses the active table, never the shadow.
- Output stage: single register. in_ready = !out_valid | out_ready. On accept, out_data <= active[in_data], out_valid <= 1. out_valid clears when out_ready & !in_fire.
- Stall: out_data/out_valid hold while out_valid & !out_ready.

## Timing
- Eval latency 1 cycle: vector accepted at edge k appears at out at edge k (visible cycle k+1); full throughput, 1 vector/cycle with out_ready=1.
- Commit: the TT_W-th bit is accepted at edge k; COMMIT occupies cycle k+1; active table and cfg_done are updated at edge k+2. A vector accepted in the COMMIT cycle uses the old table. The first vector using the new table is the one accepted in cycle k+2.
- Minimum reload period: TT_W+1 cycles.
- Reset mid-load: partial shadow discarded; active table returns to RESET_TT; any in-flight result dropped (out_valid=0).
- Simultaneous in_fire and out_ready with out_valid=1: replace the result, out_valid stays 1.

## Configuration
- LUT_CFG_PARITY_EN defined: each load is TT_W+1 bits; the final bit is even parity over the TT_W table bits. A mismatch discards the shadow without commit, cfg_done stays 0, and extra output cfg_err (out, 1) pulses for one cycle in place of cfg_done. FSM passes through COMMIT either way, so timing is identical.
- Undefined: TT_W-bit loads, no parity, no cfg_err port.

## Structure
- Package wolfram_lut_pkg: cfg FSM enum (IDLE, SHIFT, COMMIT), default table constant, function computing counter width.
- One sub-module, wolfram_lut_cfg_shifter: shadow register, bit counter, FSM, parity check, outputs shadow and commit strobe. The top holds the active table and the output stage.

## Test plan
- Reset, N_IN=3, sweep in_data 0..7 with out_ready=1 -> out_data sequence 0,1,1,0,1,1,0,1, one per cycle after 1-cycle latency.
- Load 8'h96 (bits 0,1,1,0,1,0,0,1) with no gaps while streaming vectors -> cfg_done 2 cycles after the last bit; vectors accepted up to the COMMIT cycle follow 8'hB6, vectors accepted afterwards follow 8'h96 (input 7 -> 1, input 5 -> 0).
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data stable; no vector lost or duplicated on release.
- Assert rst_n low after 4 of 8 cfg bits -> input 0 returns 0 and input 1 returns 1 (RESET_TT); a following full load of 8'hFF makes all outputs 1.
- Load with gaps of 3 idle cycles between bits -> same committed table as the gapless load.
- With LUT_CFG_PARITY_EN: 8'h96 plus parity 0 commits; 8'h97 plus parity 0 pulses cfg_err and keeps the previous table.

Source files
------------

// File: rtl/wolfram_lut_pkg.sv
// Shared types and constants for the wolfram LUT cell.
// Optional feature macro: LUT_CFG_PARITY_EN.
package wolfram_lut_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_SHIFT,
    CFG_COMMIT
  } cfg_state_e;

  localparam logic [7:0] DEFAULT_TT = 8'hB6;

  function automatic int cnt_width(input int tt_w);
    return $clog2(tt_w) + 1;
  endfunction

endpackage

// File: rtl/wolfram_lut_cell_if.sv
// Config and evaluation handshakes of the LUT cell.
// LUT_CFG_PARITY_EN adds the cfg_err strobe.
interface wolfram_lut_cell_if #(
  parameter int N_IN = 3
) ();

  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_ready;
  logic            cfg_done;
  logic            in_valid;
  logic [N_IN-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_data;
  logic            out_ready;
`ifdef LUT_CFG_PARITY_EN
  logic            cfg_err;
`endif

  modport master (
    output cfg_valid,
    output cfg_bit,
    input  cfg_ready,
    input  cfg_done,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
`ifdef LUT_CFG_PARITY_EN
    ,
    input  cfg_err
`endif
  );

  modport slave (
    input  cfg_valid,
    input  cfg_bit,
    output cfg_ready,
    output cfg_done,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
`ifdef LUT_CFG_PARITY_EN
    ,
    output cfg_err
`endif
  );

endinterface

// File: rtl/wolfram_lut_cfg_shifter.sv
// Serial table loader: shadow register, bit counter and config FSM.
// LUT_CFG_PARITY_EN adds a trailing even-parity bit per load.
module wolfram_lut_cfg_shifter
  import wolfram_lut_pkg::*;
#(
  parameter int TT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid_i,
  input  logic            cfg_bit_i,
  output logic            cfg_ready_o,
  output logic [TT_W-1:0] shadow_o,
  output logic            commit_o
`ifdef LUT_CFG_PARITY_EN
  ,
  output logic            reject_o
`endif
);

`ifdef LUT_CFG_PARITY_EN
  localparam int LOAD_BITS = TT_W + 1;
`else
  localparam int LOAD_BITS = TT_W;
`endif
  localparam int CW = cnt_width(TT_W);
  localparam logic [CW-1:0] LAST = CW'(LOAD_BITS - 1);

  cfg_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TT_W-1:0] shadow_q, shadow_d;
  logic            fire;
  logic            shift_en;
  logic            in_commit;

`ifdef LUT_CFG_PARITY_EN
  localparam logic [CW-1:0] TBITS = CW'(TT_W);
  logic par_q, par_d;
  logic par_ok;
`endif

  assign in_commit   = (state_q == CFG_COMMIT);
  assign cfg_ready_o = !in_commit;
  assign fire        = cfg_valid_i & cfg_ready_o;
  assign shadow_o    = shadow_q;

`ifdef LUT_CFG_PARITY_EN
  // The parity bit is counted but never shifted into the table.
  assign shift_en = fire && (cnt_q < TBITS);
  assign par_ok   = ((^shadow_q) == par_q);
  assign commit_o = in_commit & par_ok;
  assign reject_o = in_commit & !par_ok;
`else
  assign shift_en = fire;
  assign commit_o = in_commit;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
`ifdef LUT_CFG_PARITY_EN
    par_d    = par_q;
    if (fire && (cnt_q == TBITS))
      par_d = cfg_bit_i;
`endif
    if (shift_en)
      shadow_d = {cfg_bit_i, shadow_q[TT_W-1:1]};
    unique case (state_q)
      CFG_IDLE: begin
        if (fire) begin
          state_d = CFG_SHIFT;
          cnt_d   = CW'(1);
        end
      end
      CFG_SHIFT: begin
        if (fire) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST)
            state_d = CFG_COMMIT;
        end
      end
      CFG_COMMIT: begin
        state_d  = CFG_IDLE;
        cnt_d    = '0;
        shadow_d = '0;
      end
      default: begin
        state_d = CFG_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CFG_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
`ifdef LUT_CFG_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
`ifdef LUT_CFG_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: rtl/wolfram_lut_cell.sv
// Reprogrammable N-input truth-table cell with registered output.
// LUT_CFG_PARITY_EN enables parity-checked loads and cfg_err.
module wolfram_lut_cell
  import wolfram_lut_pkg::*;
#(
  parameter int              N_IN     = 3,
  parameter int              TT_W     = 2 ** N_IN,
  parameter logic [TT_W-1:0] RESET_TT = TT_W'(DEFAULT_TT)
) (
  input logic               clk,
  input logic               rst_n,
  wolfram_lut_cell_if.slave lut
);

  logic [TT_W-1:0] shadow;
  logic            commit;
  logic [TT_W-1:0] active_q, active_d;
  logic            out_valid_q, out_valid_d;
  logic            out_data_q, out_data_d;
  logic            cfg_done_q;
  logic            in_fire;

`ifdef LUT_CFG_PARITY_EN
  logic reject;
  logic cfg_err_q;
`endif

  wolfram_lut_cfg_shifter #(
    .TT_W (TT_W)
  ) u_cfg (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid_i (lut.cfg_valid),
    .cfg_bit_i   (lut.cfg_bit),
    .cfg_ready_o (lut.cfg_ready),
    .shadow_o    (shadow),
    .commit_o    (commit)
`ifdef LUT_CFG_PARITY_EN
    ,
    .reject_o    (reject)
`endif
  );

  assign lut.in_ready  = !out_valid_q | lut.out_ready;
  assign in_fire       = lut.in_valid & lut.in_ready;
  assign lut.out_valid = out_valid_q;
  assign lut.out_data  = out_data_q;
  assign lut.cfg_done  = cfg_done_q;
`ifdef LUT_CFG_PARITY_EN
  assign lut.cfg_err   = cfg_err_q;
`endif

  // Lookups read active_q, so a vector in the commit cycle sees the old table.
  always_comb begin
    active_d    = active_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (commit)
      active_d = shadow;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = active_q[lut.in_data];
    end else if (lut.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= RESET_TT;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
      cfg_err_q   <= 1'b0;
`endif
    end else begin
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_done_q  <= commit;
`ifdef LUT_CFG_PARITY_EN
      cfg_err_q   <= reject;
`endif
    end
  end

endmodule

// File: tb/tb_wolfram_lut_cell.sv
// Directed self-checking bench for wolfram_lut_cell (N_IN=3).
// Parity cases are built only with LUT_CFG_PARITY_EN.
module tb_wolfram_lut_cell;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wolfram_lut_cell_if #(.N_IN(3)) bus ();

  wolfram_lut_cell #(
    .N_IN (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lut   (bus)
  );

`ifdef LUT_CFG_PARITY_EN
  localparam int LB = 9;
`else
  localparam int LB = 8;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.cfg_done === 1'b1) n_done++;
`ifdef LUT_CFG_PARITY_EN
    if (bus.cfg_err === 1'b1) n_err++;
`endif
  endtask

  task automatic load(input logic [7:0] tt, input logic par,
                      input int gap);
    bus.in_valid = 1'b0;
    for (int i = 0; i < LB; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = (i < 8) ? tt[i] : par;
      tick();
      bus.cfg_valid = 1'b0;
      repeat (gap) tick();
    end
    bus.cfg_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic sweep(input string tag, input logic [7:0] exp);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 3'(i);
      tick();
      chk(tag, {31'b0, bus.out_data}, {31'b0, exp[i]});
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t_old;
    logic [7:0] t_new;
    logic [7:0] seq1;
    logic [2:0] d;

    t_old = 8'hB6;
    t_new = 8'h96;
    seq1  = 8'b1011_0110;

    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_ready", {31'b0, bus.cfg_ready}, 32'd1);
    chk("rst_cfg_done",  {31'b0, bus.cfg_done},  32'd0);
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data",  {31'b0, bus.out_data},  32'd0);
    rst_n = 1'b1;
    tick();

    // Sweep with reset table: 0,1,1,0,1,1,0,1
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 3'(i);
      tick();
      chk("t1_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("t1_data",  {31'b0, bus.out_data},  {31'b0, seq1[i]});
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t1_idle_valid", {31'b0, bus.out_valid}, 32'd0);

    // Gapless load of 8'h96 while streaming
    n_done = 0;
    for (int t = 0; t < LB + 4; t++) begin
      bus.cfg_valid = (t < LB);
      bus.cfg_bit   = (t < 8) ? t_new[t] : 1'b0;
      d = (t % 3 == 2) ? 3'd7 : 3'd5;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      chk("t2_cfg_ready", {31'b0, bus.cfg_ready},
          (t == LB - 1) ? 32'd0 : 32'd1);
      chk("t2_cfg_done", {31'b0, bus.cfg_done},
          (t == LB) ? 32'd1 : 32'd0);
      chk("t2_data", {31'b0, bus.out_data},
          {31'b0, (t <= LB) ? t_old[d] : t_new[d]});
    end
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    tick();
    chk("t2_done_cnt", n_done, 32'd1);

    // Backpressure: result held, nothing lost or doubled
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 3'd7;
    tick();
    chk("t3_first", {31'b0, bus.out_data}, 32'd1);
    bus.out_ready = 1'b0;
    bus.in_data   = 3'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_in_ready", {31'b0, bus.in_ready},  32'd0);
      chk("t3_hold_v",   {31'b0, bus.out_valid}, 32'd1);
      chk("t3_hold_d",   {31'b0, bus.out_data},  32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t3_rel_v", {31'b0, bus.out_valid}, 32'd1);
    chk("t3_rel_d", {31'b0, bus.out_data},  32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("t3_drain", {31'b0, bus.out_valid}, 32'd0);

    // Reset in the middle of a load with a stalled result
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 3'd2;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = 1'b1;
      tick();
    end
    bus.cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t4_rst_ready", {31'b0, bus.cfg_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 3'd0;
    tick();
    chk("t4_in0", {31'b0, bus.out_data}, 32'd0);
    bus.in_data = 3'd1;
    tick();
    chk("t4_in1", {31'b0, bus.out_data}, 32'd1);
    bus.in_data = 3'd5;
    tick();
    chk("t4_in5", {31'b0, bus.out_data}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    n_done = 0;
    load(8'hFF, 1'b0, 0);
    chk("t4_done_cnt", n_done, 32'd1);
    sweep("t4_ff", 8'hFF);

    // Load with 3 idle cycles between bits
    n_done = 0;
    load(8'h96, 1'b0, 3);
    chk("t5_done_cnt", n_done, 32'd1);
    sweep("t5_96", 8'b1001_0110);

`ifdef LUT_CFG_PARITY_EN
    n_done = 0;
    n_err  = 0;
    load(8'h97, 1'b0, 0);
    chk("p_bad_err",  n_err,  32'd1);
    chk("p_bad_done", n_done, 32'd0);
    sweep("p_kept_96", 8'b1001_0110);
    n_done = 0;
    n_err  = 0;
    load(8'hFF, 1'b0, 0);
    chk("p_ff_done", n_done, 32'd1);
    chk("p_ff_err",  n_err,  32'd0);
    sweep("p_ff", 8'hFF);
    n_done = 0;
    load(8'h96, 1'b0, 0);
    chk("p_96_done", n_done, 32'd1);
    sweep("p_96", 8'b1001_0110);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
